// File: rtl/root_request_arbiter_if.sv
// Signal bundle between the requesters, the root request arbiter and the
// square-root engine. The arbiter uses the slave view; whoever drives the
// requests and models the engine uses the master view.
interface root_request_arbiter_if #(
  parameter int REQUESTERS  = 2,
  parameter int WIDTH_ALPHA = 8,
  parameter int WIDTH_ROOT  = 8
);
  logic [REQUESTERS-1:0]             request;
  logic [REQUESTERS*WIDTH_ALPHA-1:0] alpha_flat;
  logic [REQUESTERS-1:0]             grant;
  logic [REQUESTERS-1:0]             done;
  logic [WIDTH_ROOT-1:0]             root_out;
  logic                              error;
  logic                              busy;
  logic                              engine_start;
  logic [WIDTH_ALPHA-1:0]            engine_alpha;
  logic                              engine_done;
  logic [WIDTH_ROOT-1:0]             engine_root;

  modport slave (
    input  request,
    input  alpha_flat,
    input  engine_done,
    input  engine_root,
    output grant,
    output done,
    output root_out,
    output error,
    output busy,
    output engine_start,
    output engine_alpha
  );

  modport master (
    output request,
    output alpha_flat,
    output engine_done,
    output engine_root,
    input  grant,
    input  done,
    input  root_out,
    input  error,
    input  busy,
    input  engine_start,
    input  engine_alpha
  );
endinterface

// File: rtl/root_request_arbiter.sv
// Round-robin front end that shares one square-root engine between several
// requesters. One job is in flight at a time: IDLE picks a winner, ISSUE
// pulses grant/start, WAIT waits for the engine (bounded by TIMEOUT) and
// REPLY hands the root back with a one-cycle done pulse.
module root_request_arbiter #(
  parameter int REQUESTERS  = 2,
  parameter int WIDTH_ALPHA = 8,
  parameter int WIDTH_ROOT  = 8,
  parameter int TIMEOUT     = 64
) (
  input logic                   clock,
  input logic                   reset,
  root_request_arbiter_if.slave bus
);

  localparam int IDXW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    REPLY = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDXW-1:0]         ptr_q;
  logic [IDXW-1:0]         idx_q;
  logic [WIDTH_ALPHA-1:0]  alpha_q;
  logic [WIDTH_ROOT-1:0]   root_q;
  logic                    err_q;
  logic [TW-1:0]           timer_q;
  logic [REQUESTERS-1:0]   grant_q;
  logic [REQUESTERS-1:0]   done_q;
  logic                    busy_q;
  logic                    start_q;

  logic                    pickValid_d;
  logic [IDXW-1:0]         pickIdx_d;
  logic [WIDTH_ALPHA-1:0]  pickAlpha_d;

  // Adds an offset below REQUESTERS to an index and wraps it, so that
  // non-power-of-two requester counts rotate correctly.
  function automatic logic [IDXW-1:0] wrapIdx(input logic [IDXW-1:0] base,
                                              input int              offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= REQUESTERS) sum = sum - REQUESTERS;
    return IDXW'(sum);
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [REQUESTERS-1:0] oneHot(input logic [IDXW-1:0] idx);
    logic [REQUESTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first active request scanning from the pointer upward.
  always_comb begin
    pickValid_d = 1'b0;
    pickIdx_d   = '0;
    pickAlpha_d = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!pickValid_d && bus.request[wrapIdx(ptr_q, k)]) begin
        pickValid_d = 1'b1;
        pickIdx_d   = wrapIdx(ptr_q, k);
      end
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (IDXW'(i) == pickIdx_d) begin
        pickAlpha_d = bus.alpha_flat[i*WIDTH_ALPHA +: WIDTH_ALPHA];
      end
    end
  end

  // Job sequencer: state, latched job data and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      alpha_q <= '0;
      root_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid_d) begin
            idx_q   <= pickIdx_d;
            alpha_q <= pickAlpha_d;
            grant_q <= oneHot(pickIdx_d);
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          grant_q <= '0;
          start_q <= 1'b0;
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.engine_done) begin
            root_q  <= bus.engine_root;
            err_q   <= 1'b0;
            done_q  <= oneHot(idx_q);
            state_q <= REPLY;
          end else if (timer_q == TIMER_LAST) begin
            root_q  <= '0;
            err_q   <= 1'b1;
            done_q  <= oneHot(idx_q);
            state_q <= REPLY;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        REPLY: begin
          done_q  <= '0;
          root_q  <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= wrapIdx(idx_q, 1);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.root_out     = root_q;
  assign bus.error        = err_q;
  assign bus.busy         = busy_q;
  assign bus.engine_start = start_q;
  assign bus.engine_alpha = alpha_q;

endmodule

// File: tb/tb_root_request_arbiter.sv
// Bench for root_request_arbiter: a two-requester instance (TIMEOUT 64) and a
// three-requester instance (TIMEOUT 6) share clock and reset. A behavioural
// engine answers each start with floor(sqrt(alpha)) after a chosen delay.
module tb_root_request_arbiter;

  localparam int TO2 = 64;
  localparam int TO3 = 6;

  typedef struct {
    int              tgt;
    logic [2:0]      req;
    logic [2:0][7:0] alpha;
    int              lat;
    bit              spur;
    int              expIdx;
    logic [7:0]      expRoot;
    bit              expErr;
  } job_t;

  logic clock = 1'b0;
  logic reset;

  int              target = 2;
  logic [2:0]      reqDrv;
  logic [2:0][7:0] alphaDrv;
  logic            engDone;
  logic [7:0]      engRoot;

  logic [7:0] grantObs, doneObs, rootObs, alphaObs;
  logic       errObs, busyObs, startObs;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  root_request_arbiter_if #(.REQUESTERS(2), .WIDTH_ALPHA(8), .WIDTH_ROOT(8)) bus2 ();
  root_request_arbiter_if #(.REQUESTERS(3), .WIDTH_ALPHA(8), .WIDTH_ROOT(8)) bus3 ();

  root_request_arbiter #(.REQUESTERS(2), .WIDTH_ALPHA(8), .WIDTH_ROOT(8), .TIMEOUT(TO2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  root_request_arbiter #(.REQUESTERS(3), .WIDTH_ALPHA(8), .WIDTH_ROOT(8), .TIMEOUT(TO3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3.slave)
  );

  // Route the bench drivers to the selected instance; the other sees zeros.
  always_comb begin
    bus2.request     = (target == 2) ? reqDrv[1:0] : 2'b00;
    bus2.alpha_flat  = (target == 2) ? {alphaDrv[1], alphaDrv[0]} : 16'h0000;
    bus2.engine_done = (target == 2) && engDone;
    bus2.engine_root = (target == 2) ? engRoot : 8'h00;
    bus3.request     = (target == 3) ? reqDrv : 3'b000;
    bus3.alpha_flat  = (target == 3) ? {alphaDrv[2], alphaDrv[1], alphaDrv[0]} : 24'h000000;
    bus3.engine_done = (target == 3) && engDone;
    bus3.engine_root = (target == 3) ? engRoot : 8'h00;
  end

  // Observe the selected instance through width-normalised signals.
  always_comb begin
    if (target == 3) begin
      grantObs = {5'b0, bus3.grant};
      doneObs  = {5'b0, bus3.done};
      rootObs  = bus3.root_out;
      alphaObs = bus3.engine_alpha;
      errObs   = bus3.error;
      busyObs  = bus3.busy;
      startObs = bus3.engine_start;
    end else begin
      grantObs = {6'b0, bus2.grant};
      doneObs  = {6'b0, bus2.done};
      rootObs  = bus2.root_out;
      alphaObs = bus2.engine_alpha;
      errObs   = bus2.error;
      busyObs  = bus2.busy;
      startObs = bus2.engine_start;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] isqrt(input logic [7:0] a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(a)) r++;
    return 8'(r);
  endfunction

  function automatic job_t mkJob(input int tgt, input logic [2:0] req,
                                 input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                 input int lat, input bit spur,
                                 input int idx, input logic [7:0] root, input bit err);
    job_t j;
    j.tgt     = tgt;
    j.req     = req;
    j.alpha   = {a2, a1, a0};
    j.lat     = lat;
    j.spur    = spur;
    j.expIdx  = idx;
    j.expRoot = root;
    j.expErr  = err;
    return j;
  endfunction

  // Runs one job from an IDLE negedge to the following IDLE negedge.
  // lat = WAIT cycle in which the engine answers; 0 means it never answers.
  task automatic applyStimulus(input job_t j);
    int         waited;
    int         cyc;
    int         to;
    int         expCyc;
    bit         seen;
    logic [7:0] expAlpha;
    logic [7:0] expHot;
    target   = j.tgt;
    to       = (j.tgt == 3) ? TO3 : TO2;
    expCyc   = (j.lat == 0 || j.lat > to) ? to + 1 : j.lat + 1;
    expAlpha = j.alpha[j.expIdx];
    expHot   = 8'b1 << j.expIdx;
    reqDrv   = j.req;
    alphaDrv = j.alpha;

    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 8) begin
      @(negedge clock);
      waited++;
      if (grantObs != 8'h00) seen = 1'b1;
    end
    checkOutput("grant latency", waited, 1);
    checkOutput("grant vector", grantObs, expHot);
    checkOutput("engine_start", startObs, 1);
    checkOutput("engine_alpha", alphaObs, expAlpha);
    checkOutput("done during grant", doneObs, 0);
    if (!seen) return;

    if (j.spur) begin
      engDone = 1'b1;
      engRoot = 8'hA5;
    end

    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < to + 20) begin
      @(negedge clock);
      cyc++;
      engDone = 1'b0;
      if (doneObs != 8'h00) begin
        seen = 1'b1;
      end else if (j.lat != 0 && cyc == j.lat) begin
        engDone = 1'b1;
        engRoot = isqrt(alphaObs);
      end
    end
    engDone = 1'b0;
    checkOutput("done latency", cyc, expCyc);
    checkOutput("done vector", doneObs, expHot);
    checkOutput("root_out", rootObs, j.expRoot);
    checkOutput("error", errObs, j.expErr);
    checkOutput("grant during done", grantObs, 0);
    checkOutput("busy during reply", busyObs, 1);

    @(negedge clock);
    checkOutput("idle busy", busyObs, 0);
    checkOutput("idle done", doneObs, 0);
    checkOutput("idle root", rootObs, 0);
  endtask

  // Time limit for the whole run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed table, hand sequences, then randomized jobs against the model.
  initial begin
    job_t       dirTable[$];
    job_t       j;
    bit         seenDone;
    int         mPtr;
    int         win;
    int         c;
    logic [2:0] rq;
    int         lat;
    bit         tOut;

    // Two requesters, TIMEOUT 64: round-robin, timeouts, last-cycle done.
    dirTable.push_back(mkJob(2, 3'b011,  81,  49, 0, 3, 0, 0,  9, 0));
    dirTable.push_back(mkJob(2, 3'b011,  81,  49, 0, 4, 0, 1,  7, 0));
    dirTable.push_back(mkJob(2, 3'b011,  81,  49, 0, 2, 0, 0,  9, 0));
    dirTable.push_back(mkJob(2, 3'b011,  81,  49, 0, 6, 0, 1,  7, 0));
    dirTable.push_back(mkJob(2, 3'b001, 144,   0, 0, 5, 0, 0, 12, 0));
    dirTable.push_back(mkJob(2, 3'b010,   0, 200, 0, 0, 0, 1,  0, 1));
    dirTable.push_back(mkJob(2, 3'b001,  25,   0, 0, 3, 0, 0,  5, 0));
    dirTable.push_back(mkJob(2, 3'b010,   0, 100, 0, 64, 1, 1, 10, 0));
    dirTable.push_back(mkJob(2, 3'b011, 255,   0, 0, 1, 0, 0, 15, 0));
    dirTable.push_back(mkJob(2, 3'b011, 255,   0, 0, 1, 1, 1,  0, 0));
    // Three requesters, TIMEOUT 6: req2 drops after its first service.
    dirTable.push_back(mkJob(3, 3'b111,   1,   4, 121, 2, 0, 0,  1, 0));
    dirTable.push_back(mkJob(3, 3'b111,   1,   4, 121, 5, 0, 1,  2, 0));
    dirTable.push_back(mkJob(3, 3'b111,   1,   4, 121, 0, 0, 2,  0, 1));
    dirTable.push_back(mkJob(3, 3'b011,   1,   4, 121, 1, 0, 0,  1, 0));
    dirTable.push_back(mkJob(3, 3'b011,   1,   4, 121, 6, 0, 1,  2, 0));
    dirTable.push_back(mkJob(3, 3'b011,   1,   4, 121, 3, 0, 0,  1, 0));
    dirTable.push_back(mkJob(3, 3'b011,   1,   4, 121, 7, 0, 1,  0, 1));

    reset    = 1'b1;
    reqDrv   = '0;
    alphaDrv = '0;
    engDone  = 1'b0;
    engRoot  = '0;
    repeat (2) @(negedge clock);
    target = 2;
    #1;
    checkOutput("reset grant/done dut2", {grantObs, doneObs}, 0);
    checkOutput("reset others dut2", {rootObs, alphaObs, errObs, busyObs, startObs}, 0);
    target = 3;
    #1;
    checkOutput("reset others dut3", {grantObs, doneObs, rootObs, errObs, busyObs, startObs}, 0);
    target = 2;
    @(negedge clock);
    reset = 1'b0;

    for (int n = 0; n < dirTable.size(); n++) begin
      if (dirTable[n].tgt == 3 && n > 0 && dirTable[n-1].tgt == 2) begin
        reqDrv = '0;
        @(negedge clock);
      end
      applyStimulus(dirTable[n]);
    end

    // Reset in the middle of a WAIT abandons the job and zeroes the pointer.
    reqDrv = '0;
    @(negedge clock);
    applyStimulus(mkJob(2, 3'b001, 16, 0, 0, 2, 0, 0, 4, 0));
    target   = 2;
    reqDrv   = 3'b010;
    alphaDrv = {8'd0, 8'd64, 8'd0};
    @(negedge clock);
    checkOutput("mid-job grant", grantObs, 2);
    reqDrv = '0;
    repeat (3) @(negedge clock);
    checkOutput("busy before reset", busyObs, 1);
    reset = 1'b1;
    #1;
    checkOutput("outputs under reset grant", grantObs, 0);
    checkOutput("outputs under reset others", {doneObs, rootObs, alphaObs, errObs, busyObs, startObs}, 0);
    @(negedge clock);
    reset    = 1'b0;
    seenDone = 1'b0;
    repeat (TO2 + 10) begin
      @(negedge clock);
      if (doneObs != 8'h00 || busyObs) seenDone = 1'b1;
    end
    checkOutput("no done after reset", seenDone, 0);
    applyStimulus(mkJob(2, 3'b011, 36, 64, 0, 4, 0, 0, 6, 0));
    applyStimulus(mkJob(2, 3'b010, 36, 64, 0, 4, 0, 1, 8, 0));

    // Randomized jobs on the three-requester instance vs the reference model.
    reqDrv = '0;
    reset  = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mPtr  = 0;
    for (int n = 0; n < 40; n++) begin
      rq  = 3'($urandom_range(1, 7));
      lat = $urandom_range(0, TO3 + 2);
      j   = mkJob(3, rq, 8'($urandom), 8'($urandom), 8'($urandom), lat, 1'($urandom_range(0, 1)), 0, 0, 0);
      win = -1;
      for (int k = 0; k < 3; k++) begin
        c = (mPtr + k) % 3;
        if (win < 0 && rq[c]) win = c;
      end
      tOut      = (lat == 0) || (lat > TO3);
      j.expIdx  = win;
      j.expErr  = tOut;
      j.expRoot = tOut ? 8'd0 : isqrt(j.alpha[win]);
      mPtr      = (win + 1) % 3;
      applyStimulus(j);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/root_request_arbiter.md
Name: root_request_arbiter

Overview:
Round-robin scheduler that shares one square-root engine between REQUESTERS independent requesters, such as a switch-input panel and a test sequencer.
It accepts a request, forwards the operand with a one-cycle start pulse, and waits for the engine's done (bounded by a timeout).
It returns the root to the winning requester with a one-cycle done pulse.
It sits between the requesters and the existing load/add/half square-root datapath wrapper.

Parameters:
REQUESTERS, 2, number of requesters (2..8)
WIDTH_ALPHA, 8, operand width
WIDTH_ROOT, 8, root width as produced by the engine
TIMEOUT, 64, maximum WAIT cycles tolerated for engine_done (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
request  input  REQUESTERS  per-requester request level; held high until granted
alpha_flat  input  REQUESTERS*WIDTH_ALPHA  operand of requester i in bits [i*WIDTH_ALPHA +: WIDTH_ALPHA]
grant  output  REQUESTERS  one-hot, one-cycle acceptance pulse
done  output  REQUESTERS  one-hot, one-cycle completion pulse
root_out  output  WIDTH_ROOT  result; valid only while done is nonzero, 0 otherwise
error  output  1  high with done when the engine timed out
busy  output  1  high whenever state is not IDLE
engine_start  output  1  one-cycle start pulse to the engine
engine_alpha  output  WIDTH_ALPHA  latched operand; stable from ISSUE through REPLY
engine_done  input  1  engine completion pulse
engine_root  input  WIDTH_ROOT  engine result; sampled when engine_done=1

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- On reset: state=IDLE; pointer=0; latched index/alpha/root/error=0; all outputs 0.
- Reset mid-operation abandons the job: no done or error is issued, and the pointer returns to 0.
- FSM states are IDLE, ISSUE, WAIT, REPLY; all outputs are decoded from registered state.
- IDLE:
  - When request!=0, select the first set bit scanning pointer, pointer+1, ... modulo REQUESTERS.
  - Latch its index and operand, then go to ISSUE.
  - When request==0, stay in IDLE.
- ISSUE (exactly 1 cycle): grant[idx]=1 and engine_start=1; go to WAIT and clear the timer. engine_done is ignored in this state.
- WAIT:
  - engine_done=1: capture engine_root, error=0, go to REPLY.
  - Otherwise, if timer==TIMEOUT-1: root=0, error=1, go to REPLY.
  - Otherwise increment the timer.
  - engine_done in the final allowed cycle wins over the timeout.
- REPLY (exactly 1 cycle): done[idx]=1; root_out=latched root; error=latched error; pointer=(idx+1) mod REQUESTERS; go to IDLE.
- Latency: a request sampled at edge k gives grant/start in cycle k+1. An engine_done sampled at edge m gives done in cycle m+1. Minimum turnaround is 4 cycles plus engine latency.
- Requests that change during ISSUE/WAIT/REPLY are not sampled. A requester still high after its done is re-arbitrated normally, behind others by round-robin.
- A request dropped before being granted is simply never served. Operand changes after IDLE sampling do not affect the job.
- grant and done are never high in the same cycle, and at most one bit of each is set.
- The timer is sized to ceil(log2(TIMEOUT+1)) bits. The pointer wraps modulo REQUESTERS, including for non-power-of-two counts.
- Only one job is outstanding at a time; there is no queueing.

Test Plan:
- Reset, then request=01, alpha0=8'd144; engine model returns 8'd12 after 5 cycles -> grant=01 in the cycle after request; engine_start one pulse with engine_alpha=144; done=01 with root_out=12 and error=0 one cycle after engine_done.
- Both requests held high continuously (alpha0=81, alpha1=49) -> service order req0, req1, req0, req1 with roots 9, 7, 9, 7; grant is never two-hot.
- Engine never asserts done, TIMEOUT=64 -> done pulses exactly 64 WAIT cycles after ISSUE, with error=1 and root_out=0; the next request is served normally.
- engine_done arriving exactly in the 64th WAIT cycle -> error=0 and the root is delivered. A spurious engine_done during ISSUE is ignored.
- Assert reset during WAIT -> all outputs go to 0 immediately; no done follows; the next request from req1 alone is granted with pointer=0 semantics.
- REQUESTERS=3, all three requesting, with req2 dropped after its first service -> order 0, 1, 2, 0, 1, 0, 1; busy low only in IDLE cycles.
